// File: rtl/design_selector.sv
// design_selector: button-driven design select for the output multiplexer, with blank/reset sequencing.
// Optional DESIGN_SELECTOR_PREV_EN enables the "previous design" button path.

module design_selector_btn #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic req
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic          sync;
   logic          level;
   logic          level_q;
   logic [DW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta    <= 1'b0;
         sync    <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
         req     <= 1'b0;
      end else begin
         meta    <= btn;
         sync    <= meta;
         level_q <= level;
         req     <= level & ~level_q;
         // Level flips only after the synchronized input has disagreed for the full window.
         if (sync == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

module design_selector #(
   parameter int unsigned NUM_DESIGNS     = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned SWITCH_GAP      = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_next_in,
   input  logic       btn_prev_in,
   output logic [2:0] design_sel_out,
   output logic       mux_en_out,
   output logic       design_rst_out,
   output logic       sel_changed_out
);

   localparam int unsigned PW = $clog2(SWITCH_GAP + 1);
   localparam logic [PW-1:0] PHASE_LAST = PW'(SWITCH_GAP - 1);
   localparam logic [2:0]    SEL_LAST   = 3'(NUM_DESIGNS - 1);

   typedef enum logic [1:0] {
      RST_HOLD,
      IDLE,
      DRAIN,
      SWAP_RST
   } state_t;

   state_t        state;
   logic [PW-1:0] phase;
   logic          go_prev;
   logic          req_next;
   logic          req_prev;
   logic [2:0]    sel_new;

   design_selector_btn #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_next (
      .clk (clk),
      .rst (rst),
      .btn (btn_next_in),
      .req (req_next)
   );

`ifdef DESIGN_SELECTOR_PREV_EN
   design_selector_btn #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_prev (
      .clk (clk),
      .rst (rst),
      .btn (btn_prev_in),
      .req (req_prev)
   );
`else
   logic unused_prev;
   assign unused_prev = btn_prev_in;
   assign req_prev    = 1'b0;
`endif

   always_comb begin
      sel_new = '0;
      if (go_prev) begin
         sel_new = (design_sel_out == 3'd0 || design_sel_out > SEL_LAST) ? SEL_LAST
                                                                        : design_sel_out - 3'd1;
      end else begin
         sel_new = (design_sel_out >= SEL_LAST) ? 3'd0 : design_sel_out + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= RST_HOLD;
         phase           <= '0;
         go_prev         <= 1'b0;
         design_sel_out  <= '0;
         mux_en_out      <= 1'b0;
         design_rst_out  <= 1'b1;
         sel_changed_out <= 1'b0;
      end else begin
         sel_changed_out <= 1'b0;
         case (state)
            RST_HOLD: begin
               if (phase == PHASE_LAST) begin
                  state          <= IDLE;
                  phase          <= '0;
                  mux_en_out     <= 1'b1;
                  design_rst_out <= 1'b0;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            IDLE: begin
               // Simultaneous next/prev requests cancel each other.
               if (req_next ^ req_prev) begin
                  state      <= DRAIN;
                  phase      <= '0;
                  go_prev    <= req_prev;
                  mux_en_out <= 1'b0;
               end
            end
            DRAIN: begin
               if (phase == PHASE_LAST) begin
                  state          <= SWAP_RST;
                  phase          <= '0;
                  design_sel_out <= sel_new;
                  design_rst_out <= 1'b1;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            SWAP_RST: begin
               if (phase == PHASE_LAST) begin
                  state           <= IDLE;
                  phase           <= '0;
                  mux_en_out      <= 1'b1;
                  design_rst_out  <= 1'b0;
                  sel_changed_out <= 1'b1;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            default: begin
               state          <= RST_HOLD;
               phase          <= '0;
               mux_en_out     <= 1'b0;
               design_rst_out <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_design_selector.sv
// Directed self-checking bench for design_selector (NUM_DESIGNS=8, DEBOUNCE_CYCLES=4, SWITCH_GAP=3).
// Define DESIGN_SELECTOR_PREV_EN for both bench and RTL to cover the previous-button path.

module tb_design_selector;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_next_in;
   logic       btn_prev_in;
   logic [2:0] design_sel_out;
   logic       mux_en_out;
   logic       design_rst_out;
   logic       sel_changed_out;

   int         tests  = 0;
   int         failed = 0;
   logic [2:0] cur;

   design_selector #(
      .NUM_DESIGNS     (8),
      .DEBOUNCE_CYCLES (4),
      .SWITCH_GAP      (3)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .btn_next_in     (btn_next_in),
      .btn_prev_in     (btn_prev_in),
      .design_sel_out  (design_sel_out),
      .mux_en_out      (mux_en_out),
      .design_rst_out  (design_rst_out),
      .sel_changed_out (sel_changed_out)
   );

   always #20 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full press/switch sequence: request reaches the FSM on the 8th edge after the press.
   task automatic do_switch(input bit use_prev, input logic [2:0] nw);
      logic [2:0] old;
      old = cur;
      if (use_prev) btn_prev_in = 1'b1;
      else          btn_next_in = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (i == 10) begin
            btn_next_in = 1'b0;
            btn_prev_in = 1'b0;
         end
         if (i <= 7) begin
            chk("pre_mux", {3'b0, mux_en_out}, 4'd1);
            chk("pre_sel", {1'b0, design_sel_out}, {1'b0, old});
         end else if (i <= 10) begin
            chk("drain_mux", {3'b0, mux_en_out}, 4'd0);
            chk("drain_rst", {3'b0, design_rst_out}, 4'd0);
            chk("drain_sel", {1'b0, design_sel_out}, {1'b0, old});
         end else if (i <= 13) begin
            chk("swap_mux", {3'b0, mux_en_out}, 4'd0);
            chk("swap_rst", {3'b0, design_rst_out}, 4'd1);
            chk("swap_sel", {1'b0, design_sel_out}, {1'b0, nw});
         end else if (i == 14) begin
            chk("live_mux", {3'b0, mux_en_out}, 4'd1);
            chk("live_rst", {3'b0, design_rst_out}, 4'd0);
            chk("live_sel", {1'b0, design_sel_out}, {1'b0, nw});
         end
         chk("chg_pulse", {3'b0, sel_changed_out}, (i == 14) ? 4'd1 : 4'd0);
      end
      cur = nw;
      repeat (10) tick();
   endtask

   initial begin
      rst         = 1'b1;
      btn_next_in = 1'b0;
      btn_prev_in = 1'b0;
      cur         = 3'd0;

      // Reset and hold-off after release
      repeat (5) tick();
      chk("rst_sel", {1'b0, design_sel_out}, 4'd0);
      chk("rst_mux", {3'b0, mux_en_out}, 4'd0);
      chk("rst_drst", {3'b0, design_rst_out}, 4'd1);
      chk("rst_chg", {3'b0, sel_changed_out}, 4'd0);
      rst = 1'b0;
      tick();
      chk("hold1_mux", {3'b0, mux_en_out}, 4'd0);
      chk("hold1_drst", {3'b0, design_rst_out}, 4'd1);
      tick();
      chk("hold2_mux", {3'b0, mux_en_out}, 4'd0);
      tick();
      chk("hold3_mux", {3'b0, mux_en_out}, 4'd1);
      chk("hold3_drst", {3'b0, design_rst_out}, 4'd0);
      chk("hold3_sel", {1'b0, design_sel_out}, 4'd0);
      repeat (4) tick();

      // Eight next presses: 1..7 then wrap to 0
      for (int n = 0; n < 8; n++) do_switch(1'b0, cur + 3'd1);
      chk("wrap_sel", {1'b0, design_sel_out}, 4'd0);

`ifdef DESIGN_SELECTOR_PREV_EN
      do_switch(1'b1, 3'd7);
      do_switch(1'b0, 3'd0);
`endif

      // Bouncing button never settles long enough
      for (int i = 0; i < 20; i++) begin
         btn_next_in = ((i / 2) % 2) == 0;
         tick();
         chk("bounce_mux", {3'b0, mux_en_out}, 4'd1);
      end
      btn_next_in = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("bounce_mux_after", {3'b0, mux_en_out}, 4'd1);
         chk("bounce_chg", {3'b0, sel_changed_out}, 4'd0);
      end
      chk("bounce_sel", {1'b0, design_sel_out}, {1'b0, cur});

`ifdef DESIGN_SELECTOR_PREV_EN
      // Both buttons rising together: no switch
      btn_next_in = 1'b1;
      btn_prev_in = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 10) begin
            btn_next_in = 1'b0;
            btn_prev_in = 1'b0;
         end
         chk("both_mux", {3'b0, mux_en_out}, 4'd1);
      end
      chk("both_sel", {1'b0, design_sel_out}, {1'b0, cur});
      repeat (6) tick();

      // Prev request lands during DRAIN of a next switch and is dropped
      btn_next_in = 1'b1;
      tick();
      tick();
      btn_prev_in = 1'b1;
      for (int i = 3; i <= 20; i++) begin
         tick();
         if (i == 10) begin
            btn_next_in = 1'b0;
            btn_prev_in = 1'b0;
         end
      end
      chk("drop_sel", {1'b0, design_sel_out}, {1'b0, cur + 3'd1});
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("drop_mux", {3'b0, mux_en_out}, 4'd1);
      end
      cur = cur + 3'd1;
      chk("drop_sel_final", {1'b0, design_sel_out}, {1'b0, cur});
`endif

      // Reset during SWAP_RST abandons the switch
      btn_next_in = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         tick();
         if (i == 5) btn_next_in = 1'b0;
      end
      chk("mid_sel_new", {1'b0, design_sel_out}, {1'b0, cur + 3'd1});
      chk("mid_drst", {3'b0, design_rst_out}, 4'd1);
      rst = 1'b1;
      tick();
      chk("mid_rst_sel", {1'b0, design_sel_out}, 4'd0);
      chk("mid_rst_mux", {3'b0, mux_en_out}, 4'd0);
      chk("mid_rst_drst", {3'b0, design_rst_out}, 4'd1);
      chk("mid_rst_chg", {3'b0, sel_changed_out}, 4'd0);
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         chk("mid_after_chg", {3'b0, sel_changed_out}, 4'd0);
         if (i == 2) chk("mid_after_mux2", {3'b0, mux_en_out}, 4'd0);
         if (i == 3) begin
            chk("mid_after_mux3", {3'b0, mux_en_out}, 4'd1);
            chk("mid_after_drst3", {3'b0, design_rst_out}, 4'd0);
         end
      end
      cur = 3'd0;
      chk("mid_final_sel", {1'b0, design_sel_out}, {1'b0, cur});

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
